abs_diff_seq_4b: RTL and testbench
==================================

ABS_DIFF_SEQ_4B -- requirements
Module: abs_diff_seq_4b

Interface
- REQ-001: Parameters: none; operand and result width fixed at 4 bits.
- REQ-002: clk  input  1  the single clock; all state updates on its rising edge.
- REQ-003: rst  input  1  reset, synchronous and active-high.
- REQ-004: istream_val  input  1  operand pair valid.
- REQ-005: istream_rdy  output  1  block can accept an operand pair.
- REQ-006: in0  input  4  unsigned operand A.
- REQ-007: in1  input  4  unsigned operand B.
- REQ-008: ostream_val  output  1  result valid.
- REQ-009: ostream_rdy  input  1  consumer can take the result.
- REQ-010: out  output  4  unsigned |in0 - in1|.

Function
- REQ-011: The block SHALL implement a three-state FSM with states IDLE, CALC and DONE.
- REQ-012: In IDLE, istream_rdy SHALL be 1, ostream_val 0 and out 0.
- REQ-013: An input handshake SHALL occur when istream_val && istream_rdy at a rising edge, and inputs SHALL be sampled only then.
- REQ-014: On handshake, registers SHALL load as follows: hi <= max(in0,in1), lo <= min(in0,in1) (unsigned greater-than compare; ties give hi=in0), cnt <= 0. The FSM SHALL then go to CALC.
- REQ-015: In CALC, istream_rdy and ostream_val SHALL be 0.
  - If lo != hi: lo <= lo+1 and cnt <= cnt+1.
  - If lo == hi: next state DONE.
- REQ-016: Every add SHALL be 4-bit, and wrap-around cannot occur because lo never exceeds hi.
- REQ-017: In DONE, ostream_val SHALL be 1, out SHALL equal cnt, and istream_rdy SHALL be 0.
- REQ-018: In DONE, out SHALL stay stable while ostream_rdy = 0 (backpressure held indefinitely).
- REQ-019: On ostream_val && ostream_rdy, the FSM SHALL return to IDLE. A new input SHALL NOT be accepted in that same cycle.
- REQ-020: Latency SHALL be as follows, with d = |in0-in1| and handshake in cycle N:
  - ostream_val rises in cycle N+d+2.
  - The maximum is d=15, giving 17 cycles.
- REQ-021: At most one operation SHALL be in flight; no buffering.

Reset
- REQ-022: While rst = 1 at a rising edge, the state SHALL become IDLE and hi, lo and cnt SHALL become 0.
- REQ-023: During cycles with rst = 1, istream_rdy and ostream_val SHALL be forced to 0.
- REQ-024: Reset in CALC or DONE SHALL abandon the in-flight operation with no result emitted.

Configuration
- REQ-025: Macro ABS_DIFF_SEQ_FASTPATH_EN.
  - Defined: on handshake with in0 == in1, the FSM SHALL go directly IDLE->DONE with cnt = 0, giving latency N+1.
  - Undefined: equal operands SHALL take the normal CALC path, giving latency N+2.
- REQ-026: Behaviour for in0 != in1 SHALL be identical with and without ABS_DIFF_SEQ_FASTPATH_EN.

Structure
- REQ-027: Shared package abs_diff_seq_pkg SHALL hold:
  - the state typedef (2 bits: IDLE=0, CALC=1, DONE=2);
  - the width constant ABS_DIFF_W = 4.
- REQ-028: The datapath (hi/lo/cnt registers, comparator, incrementers, equality check) SHALL live in sub-module abs_diff_seq_4b_dpath.
- REQ-029: The FSM and handshake logic SHALL live in the top module.
- REQ-030: The unreachable state encoding 3 SHALL transition to IDLE.

Verification
- REQ-031: in0=9, in1=4, ostream_rdy=1 -> out=5 with ostream_val high exactly 7 cycles after handshake; then istream_rdy=1 the next cycle.
- REQ-032: in0=2, in1=15 -> out=13 after 15 cycles. Then in0=15, in1=0 -> out=15 after 17 cycles.
- REQ-033: in0=in1=7 -> out=0 after 1 cycle with ABS_DIFF_SEQ_FASTPATH_EN, or after 2 cycles without.
- REQ-034: in0=3, in1=8, ostream_rdy=0 for 5 cycles after ostream_val rises -> out stays 5, istream_rdy stays 0, and istream_val pulses are ignored.
- REQ-035: rst asserted 2 cycles into CALC (in0=0, in1=12) -> next cycle IDLE with istream_rdy=1 and no result emitted. A subsequent in0=1, in1=0 -> out=1.
- REQ-036: Random back-to-back pairs with random ostream_rdy -> every out equals |in0-in1| in order, none dropped or duplicated.

Source files
------------

// File: rtl/abs_diff_seq_pkg.sv
// abs_diff_seq_pkg -- shared types and constants for abs_diff_seq_4b.
//   state_t    : FSM state encoding (IDLE=0, CALC=1, DONE=2; 3 is unused)
//   ABS_DIFF_W : operand / result width
package abs_diff_seq_pkg;

   localparam int ABS_DIFF_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/abs_diff_seq_4b_dpath.sv
// abs_diff_seq_4b_dpath -- datapath for the sequential absolute difference.
// Holds hi/lo/cnt; |a-b| is found by stepping lo up to hi and counting steps.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears hi/lo/cnt)
//   load       : capture max/min of in0/in1 into hi/lo, clear cnt
//   step       : lo <= lo+1, cnt <= cnt+1
//   in0, in1   : unsigned operands
//   eq         : lo == hi (counting finished)
//   cnt        : current step count (the result once eq is seen)
module abs_diff_seq_4b_dpath
   import abs_diff_seq_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic [ABS_DIFF_W-1:0] in0,
   input  logic [ABS_DIFF_W-1:0] in1,
   output logic                  eq,
   output logic [ABS_DIFF_W-1:0] cnt
);

   logic [ABS_DIFF_W-1:0] hi, lo;
   logic                  b_gt_a;

   // Ties fall to hi=in0, lo=in1 (same value either way).
   assign b_gt_a = (in1 > in0);
   assign eq     = (lo == hi);

   always_ff @(posedge clk) begin
      if (rst) begin
         hi  <= '0;
         lo  <= '0;
         cnt <= '0;
      end else if (load) begin
         hi  <= b_gt_a ? in1 : in0;
         lo  <= b_gt_a ? in0 : in1;
         cnt <= '0;
      end else if (step) begin
         // lo never passes hi, so neither add can wrap.
         lo  <= lo + 1'b1;
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/abs_diff_seq_4b.sv
// abs_diff_seq_4b -- 4-bit unsigned |in0 - in1| computed by a counting FSM.
// One operation in flight; result held under backpressure.
// Optional macro ABS_DIFF_SEQ_FASTPATH_EN: equal operands skip CALC and go
// straight IDLE->DONE (result 0 one cycle earlier).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   istream_val/istream_rdy: operand pair handshake
//   in0, in1               : unsigned operands
//   ostream_val/ostream_rdy: result handshake
//   out                    : |in0 - in1|, valid while ostream_val (0 otherwise)
module abs_diff_seq_4b
   import abs_diff_seq_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  istream_val,
   output logic                  istream_rdy,
   input  logic [ABS_DIFF_W-1:0] in0,
   input  logic [ABS_DIFF_W-1:0] in1,
   output logic                  ostream_val,
   input  logic                  ostream_rdy,
   output logic [ABS_DIFF_W-1:0] out
);

   state_t                state, nxt;
   logic                  load, step, eq;
   logic                  irdy, oval;
   logic [ABS_DIFF_W-1:0] cnt;

   abs_diff_seq_4b_dpath u_dpath (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .step (step),
      .in0  (in0),
      .in1  (in1),
      .eq   (eq),
      .cnt  (cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt  = state;
      load = 1'b0;
      step = 1'b0;
      irdy = 1'b0;
      oval = 1'b0;
      out  = '0;
      case (state)
         IDLE: begin
            irdy = 1'b1;
            if (istream_val && !rst) begin
               load = 1'b1;
               nxt  = CALC;
`ifdef ABS_DIFF_SEQ_FASTPATH_EN
               if (in0 == in1) nxt = DONE;
`endif
            end
         end
         CALC: begin
            if (eq) nxt  = DONE;
            else    step = 1'b1;
         end
         DONE: begin
            oval = 1'b1;
            out  = cnt;
            // istream_rdy stays low here, so no input is taken on the
            // same edge the result leaves.
            if (ostream_rdy) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Handshake outputs are masked for the whole reset cycle.
   assign istream_rdy = irdy & ~rst;
   assign ostream_val = oval & ~rst;

endmodule

// File: tb/tb_abs_diff_seq_4b.sv
// tb_abs_diff_seq_4b -- directed + random checks for abs_diff_seq_4b.
// Expected latency for equal operands follows ABS_DIFF_SEQ_FASTPATH_EN.
module tb_abs_diff_seq_4b;

   logic       clk = 1'b0;
   logic       rst;
   logic       istream_val, istream_rdy;
   logic [3:0] in0, in1;
   logic       ostream_val, ostream_rdy;
   logic [3:0] out;

   int total = 0;
   int bad   = 0;

   abs_diff_seq_4b dut (
      .clk         (clk),
      .rst         (rst),
      .istream_val (istream_val),
      .istream_rdy (istream_rdy),
      .in0         (in0),
      .in1         (in1),
      .ostream_val (ostream_val),
      .ostream_rdy (ostream_rdy),
      .out         (out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one operation from IDLE. hold = cycles of ostream_rdy=0 after
   // ostream_val is seen (0 means ostream_rdy held high throughout).
   task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input int exp_out, input int exp_lat, input int hold);
      int lat;
      in0 = a; in1 = b; istream_val = 1'b1;
      ostream_rdy = (hold == 0);
      chk({tag, " irdy_pre"}, istream_rdy, 1);
      @(posedge clk); #1;
      istream_val = 1'b0;
      lat = 1;
      while (!ostream_val && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " out"}, out, exp_out);
      chk({tag, " irdy_done"}, istream_rdy, 0);
      for (int i = 0; i < hold; i++) begin
         istream_val = 1'b1; in0 = 4'd0; in1 = 4'd15;
         @(posedge clk); #1;
         istream_val = 1'b0;
         chk({tag, " hold_out"}, out, exp_out);
         chk({tag, " hold_val"}, ostream_val, 1);
         chk({tag, " hold_irdy"}, istream_rdy, 0);
      end
      ostream_rdy = 1'b1;
      @(posedge clk); #1;
      ostream_rdy = 1'b0;
      chk({tag, " irdy_after"}, istream_rdy, 1);
      chk({tag, " val_after"}, ostream_val, 0);
   endtask

   function automatic int absd(input logic [3:0] a, input logic [3:0] b);
      return (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
   endfunction

   int eq_lat;
   int exp_q[$];
   int got, sent, cyc, lat;
   logic hs, oc;

   initial begin
`ifdef ABS_DIFF_SEQ_FASTPATH_EN
      eq_lat = 1;
`else
      eq_lat = 2;
`endif
      rst = 1'b1; istream_val = 1'b0; ostream_rdy = 1'b0; in0 = '0; in1 = '0;
      @(posedge clk); #1;
      chk("rst irdy", istream_rdy, 0);
      chk("rst oval", ostream_val, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("idle irdy", istream_rdy, 1);
      chk("idle oval", ostream_val, 0);
      chk("idle out", out, 0);

      run_op("9-4", 4'd9, 4'd4, 5, 7, 0);
      run_op("2-15", 4'd2, 4'd15, 13, 15, 0);
      run_op("15-0", 4'd15, 4'd0, 15, 17, 0);
      run_op("7-7", 4'd7, 4'd7, 0, eq_lat, 0);
      run_op("3-8 bp", 4'd3, 4'd8, 5, 7, 5);

      // Reset two cycles into CALC abandons the operation.
      in0 = 4'd0; in1 = 4'd12; istream_val = 1'b1;
      @(posedge clk); #1;
      istream_val = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst irdy", istream_rdy, 0);
      chk("midrst oval", ostream_val, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("postrst irdy", istream_rdy, 1);
      ostream_rdy = 1'b1;
      lat = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (ostream_val) lat++;
      end
      ostream_rdy = 1'b0;
      chk("postrst no result", lat, 0);
      run_op("1-0", 4'd1, 4'd0, 1, 3, 0);

      // Random back-to-back stream with random backpressure.
      sent = 0; got = 0; cyc = 0;
      in0 = 4'($urandom_range(0, 15)); in1 = 4'($urandom_range(0, 15));
      istream_val = 1'b1;
      ostream_rdy = 1'($urandom_range(0, 1));
      while (got < 20 && cyc < 2000) begin
         hs = istream_val && istream_rdy;
         oc = ostream_val && ostream_rdy;
         @(posedge clk);
         if (hs) begin
            exp_q.push_back(absd(in0, in1));
            sent++;
         end
         if (oc) begin
            if (exp_q.size() == 0) chk("rand extra result", 1, 0);
            else chk("rand out", out, exp_q.pop_front());
            got++;
         end
         #1;
         if (hs) begin
            in0 = 4'($urandom_range(0, 15)); in1 = 4'($urandom_range(0, 15));
         end
         istream_val = (sent < 20);
         ostream_rdy = 1'($urandom_range(0, 1));
         cyc++;
      end
      chk("rand count", got, 20);
      chk("rand leftover", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
